spi_adc_scan: RTL and testbench

- Parametrised N-channel SPI ADC scanner; next generation of the fixed two-channel SPI ADC top.
- Drives one SPI ADC (mode 0, 12-bit class) and converts each enabled channel in ascending order per scan.
- Supports one-shot or continuous scan and per-channel enable masking.
- Emits a tagged per-sample valid pulse plus a parallel result bank for the downstream processing blocks.

---
 rtl/spi_adc_pkg.sv | 28 ++
 rtl/spi_adc_scan_if.sv | 15 +
 rtl/spi_adc_frame.sv | 122 ++++++++++++
 rtl/spi_adc_scan.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_adc_scan.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_pkg.sv
// Shared definitions for the N-channel SPI ADC scanner.
//   scan_state_e : scanner FSM encoding (IDLE, SETUP, SHIFT, GAP, NEXT)
//   chw_f()      : channel-address width, max(1, clog2(n))
//   START_POS / SGL_POS / ADDR_POS : bit positions within a frame, counted from
//                  the first bit sent; the null bit sits at NULL_OFS + CHW and
//                  the DW result bits follow it
//   AVG_CNT      : frames per channel when averaging is compiled in
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_NEXT
    } scan_state_e;

    localparam int START_POS = 0;
    localparam int SGL_POS   = 1;
    localparam int ADDR_POS  = 2;
    localparam int NULL_OFS  = 2;
    localparam int AVG_CNT   = 4;

    function automatic int chw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_adc_scan_if.sv
// SPI pin bundle between the frame engine and the ADC.
//   cs   : chip select, active-low
//   dclk : SPI clock, idle low
//   mosi : command bits to the ADC
//   miso : ADC serial data
// master = frame engine side, slave = ADC side.
interface spi_adc_scan_if;
    logic cs;
    logic dclk;
    logic mosi;
    logic miso;

    modport master (output cs, output dclk, output mosi, input miso);
    modport slave  (input cs, input dclk, input mosi, output miso);
endinterface

// File: rtl/spi_adc_frame.sv
// Single SPI mode-0 frame engine: dclk divider, cs timing, MOSI shift-out and
// MISO shift-in for one conversion.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   go_i, ch_i   : start a frame for channel ch_i (only honoured when idle)
//   done_o       : high in the cycle that ends the frame (cs rises on that edge)
//   data_o       : DW-bit result, MSB first off miso
//   spi          : SPI pins (master side)
// cs low: HALF_DIV cycles of setup, then FRAME periods of HALF_DIV high plus
// HALF_DIV low; cs rises at the end of the last low half.
module spi_adc_frame
    import spi_adc_pkg::*;
#(
    parameter int DW       = 12,
    parameter int CHW      = 1,
    parameter int HALF_DIV = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic [CHW-1:0]    ch_i,
    output logic              done_o,
    output logic [DW-1:0]     data_o,
    spi_adc_scan_if.master    spi
);

    localparam int FRAME    = NULL_OFS + CHW + 1 + DW;
    localparam int DATA_POS = NULL_OFS + CHW + 1;
    localparam int CW       = $clog2(HALF_DIV);
    localparam int BW       = $clog2(FRAME);

    logic             run_q, run_d;       // cs is low
    logic             shift_q, shift_d;   // setup over, dclk periods running
    logic             cs_q, cs_d;
    logic             dclk_q, dclk_d;
    logic             mosi_q, mosi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;       // index of the bit on the wire
    logic [FRAME-1:0] tx_q, tx_d;         // MSB is the bit currently on mosi
    logic [DW-1:0]    rx_q, rx_d;

    always_comb begin
        // NOTE: every _d starts from its _q value so no path leaves it unassigned (no latch).
        run_d   = run_q;
        shift_d = shift_q;
        cs_d    = cs_q;
        dclk_d  = dclk_q;
        mosi_d  = mosi_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        done_o  = 1'b0;

        if (!run_q) begin
            if (go_i) begin
                run_d   = 1'b1;
                shift_d = 1'b0;
                cs_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = '0;
                tx_d[FRAME-1-START_POS]     = 1'b1;
                tx_d[FRAME-1-SGL_POS]       = 1'b1;
                tx_d[FRAME-1-ADDR_POS -: CHW] = ch_i;
                mosi_d  = tx_d[FRAME-1];
            end
        end else if (cnt_q != CW'(HALF_DIV - 1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (dclk_q) begin
                // Falling edge: present the next command bit while dclk is low.
                dclk_d = 1'b0;
                tx_d   = {tx_q[FRAME-2:0], 1'b0};
                mosi_d = tx_q[FRAME-2];
            end else if (shift_q && bit_q == BW'(FRAME - 1)) begin
                done_o  = 1'b1;
                run_d   = 1'b0;
                shift_d = 1'b0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
            end else begin
                // Rising edge: the first one ends setup and belongs to bit 0.
                dclk_d  = 1'b1;
                shift_d = 1'b1;
                if (shift_q) bit_d = bit_q + 1'b1;
                if (int'(bit_d) >= DATA_POS) rx_d = {rx_q[DW-2:0], spi.miso};
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q   <= 1'b0;
            shift_q <= 1'b0;
            cs_q    <= 1'b1;
            dclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            run_q   <= run_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            dclk_q  <= dclk_d;
            mosi_q  <= mosi_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign spi.cs   = cs_q;
    assign spi.dclk = dclk_q;
    assign spi.mosi = mosi_q;
    assign data_o   = rx_q;

endmodule

// File: rtl/spi_adc_scan.sv
// N-channel SPI ADC scanner: converts each enabled channel in ascending order,
// one-shot or continuous, with a tagged valid pulse and a parallel result bank.
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   start_i        : scan request (ignored while busy or with an empty mask)
//   cont_i         : rescan after the last channel while high
//   ch_mask_i      : channel enables, sampled when a scan starts
//   miso_i / mosi_o / dclk_o / cs_o : SPI pins
//   busy_o         : scan in progress
//   valid_o, data_o, ch_o : one-cycle tagged sample
//   dout_o         : result bank, slot k = dout_o[k*DW +: DW]
//   eos_o          : one-cycle end-of-scan pulse, coincident with the last valid_o
// Macro SPI_ADC_SCAN_AVG_EN: convert each channel AVG_CNT times and report the
// truncated mean; undefined gives one frame per channel.
module spi_adc_scan
    import spi_adc_pkg::*;
#(
    parameter int  NCH      = 2,
    parameter int  DW       = 12,
    parameter int  HALF_DIV = 20,
    parameter int  CS_GAP   = 4,
    localparam int CHW      = chw_f(NCH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [NCH-1:0]    ch_mask_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic              dclk_o,
    output logic              cs_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    output logic [CHW-1:0]    ch_o,
    output logic [NCH*DW-1:0] dout_o,
    output logic              eos_o
);

    localparam int GW = $clog2(CS_GAP + 1);

    spi_adc_scan_if u_bus ();

    assign cs_o       = u_bus.cs;
    assign dclk_o     = u_bus.dclk;
    assign mosi_o     = u_bus.mosi;
    assign u_bus.miso = miso_i;

    scan_state_e       state_q, state_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic              rescan_q, rescan_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              valid_q, valid_d;
    logic              eos_q, eos_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CHW-1:0]    cho_q, cho_d;
    logic [NCH*DW-1:0] dout_q, dout_d;

    logic              go;
    logic [CHW-1:0]    go_ch;
    logic              frm_done;
    logic [DW-1:0]     frm_data;
    logic [CHW:0]      found;             // {hit, index}
    logic [DW-1:0]     sample;
`ifdef SPI_ADC_SCAN_AVG_EN
    logic [DW+1:0]     acc_q, acc_d;
    logic [1:0]        rep_q, rep_d;
    logic [DW+1:0]     sum;
`endif

    // Lowest enabled channel at or above lo; the top-down loop lets the lowest win.
    function automatic logic [CHW:0] find_ch(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] r;
        r = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k] && k >= lo) r = {1'b1, CHW'(k)};
        end
        return r;
    endfunction

    spi_adc_frame #(.DW(DW), .CHW(CHW), .HALF_DIV(HALF_DIV)) u_frame (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .go_i   (go),
        .ch_i   (go_ch),
        .done_o (frm_done),
        .data_o (frm_data),
        .spi    (u_bus.master)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        rescan_d = rescan_q;
        gap_d    = gap_q;
        valid_d  = 1'b0;
        eos_d    = 1'b0;
        data_d   = data_q;
        cho_d    = cho_q;
        dout_d   = dout_q;
        go       = 1'b0;
        go_ch    = ch_q;
        found    = '0;
        sample   = frm_data;
`ifdef SPI_ADC_SCAN_AVG_EN
        acc_d    = acc_q;
        rep_d    = rep_q;
        sum      = acc_q + (DW+2)'(frm_data);
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i && ch_mask_i != '0) begin
                    found    = find_ch(ch_mask_i, 0);
                    mask_d   = ch_mask_i;
                    ch_d     = found[CHW-1:0];
                    go       = 1'b1;
                    go_ch    = found[CHW-1:0];
                    rescan_d = 1'b0;
                    state_d  = ST_SETUP;
`ifdef SPI_ADC_SCAN_AVG_EN
                    acc_d    = '0;
                    rep_d    = '0;
`endif
                end
            end

            ST_SETUP: begin
                if (u_bus.dclk) state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (frm_done) begin
                    gap_d   = '0;
                    state_d = (CS_GAP > 1) ? ST_GAP : ST_NEXT;
`ifdef SPI_ADC_SCAN_AVG_EN
                    if (rep_q != 2'(AVG_CNT - 1)) begin
                        acc_d = sum;
                        rep_d = rep_q + 1'b1;
                    end else begin
                        sample = sum[DW+1:2];
                        acc_d  = '0;
                        rep_d  = '0;
`endif
                        valid_d = 1'b1;
                        data_d  = sample;
                        cho_d   = ch_q;
                        dout_d[ch_q*DW +: DW] = sample;
                        found   = find_ch(mask_q, int'(ch_q) + 1);
                        if (!found[CHW]) begin
                            eos_d = 1'b1;
                            if (cont_i) rescan_d = 1'b1;
                            else        state_d  = ST_IDLE;
                        end
`ifdef SPI_ADC_SCAN_AVG_EN
                    end
`endif
                end
            end

            // The NEXT cycle is the last cs-high cycle, so GAP covers CS_GAP-1.
            ST_GAP: begin
                if (gap_q == GW'(CS_GAP - 2)) state_d = ST_NEXT;
                else                          gap_d   = gap_q + 1'b1;
            end

            ST_NEXT: begin
                state_d = ST_SETUP;
`ifdef SPI_ADC_SCAN_AVG_EN
                if (rep_q != '0) begin
                    go = 1'b1;
                end else
`endif
                if (rescan_q) begin
                    rescan_d = 1'b0;
                    if (ch_mask_i == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        found  = find_ch(ch_mask_i, 0);
                        mask_d = ch_mask_i;
                        ch_d   = found[CHW-1:0];
                        go     = 1'b1;
                        go_ch  = found[CHW-1:0];
                    end
                end else begin
                    found = find_ch(mask_q, int'(ch_q) + 1);
                    ch_d  = found[CHW-1:0];
                    go    = 1'b1;
                    go_ch = found[CHW-1:0];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            rescan_q <= 1'b0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            eos_q    <= 1'b0;
            data_q   <= '0;
            cho_q    <= '0;
            // NOTE: the result bank is ordinary flops, not a RAM, so it resets like any register.
            dout_q   <= '0;
`ifdef SPI_ADC_SCAN_AVG_EN
            acc_q    <= '0;
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            rescan_q <= rescan_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            eos_q    <= eos_d;
            data_q   <= data_d;
            cho_q    <= cho_d;
            dout_q   <= dout_d;
`ifdef SPI_ADC_SCAN_AVG_EN
            acc_q    <= acc_d;
            rep_q    <= rep_d;
`endif
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = valid_q;
    assign eos_o   = eos_q;
    assign data_o  = data_q;
    assign ch_o    = cho_q;
    assign dout_o  = dout_q;

endmodule

// File: tb/tb_spi_adc_scan.sv
// Directed self-checking bench for spi_adc_scan at default parameters, with a
// behavioural mode-0 ADC on an spi_adc_scan_if slave bundle.
module tb_spi_adc_scan;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int CHW = 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic              cont_i = 1'b0;
    logic [NCH-1:0]    ch_mask_i = '0;
    wire               miso_i;
    logic              mosi_o, dclk_o, cs_o, busy_o, valid_o, eos_o;
    logic [DW-1:0]     data_o;
    logic [CHW-1:0]    ch_o;
    logic [NCH*DW-1:0] dout_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    spi_adc_scan dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .cont_i    (cont_i),
        .ch_mask_i (ch_mask_i),
        .miso_i    (miso_i),
        .mosi_o    (mosi_o),
        .dclk_o    (dclk_o),
        .cs_o      (cs_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ch_o      (ch_o),
        .dout_o    (dout_o),
        .eos_o     (eos_o)
    );

    // ADC model: mode 0 = miso tied high, 1 = per-channel value, 2 = 100+frame index
    spi_adc_scan_if adc_bus ();
    assign adc_bus.cs   = cs_o;
    assign adc_bus.dclk = dclk_o;
    assign adc_bus.mosi = mosi_o;
    assign miso_i       = adc_bus.miso;

    int          mode = 0;
    logic [11:0] val0 = 12'hA5C;
    logic [11:0] val1 = 12'h3F1;
    int          nfall = 0;
    int          frames = 0;
    logic        addr = 1'b0;
    logic [15:0] mosi_bits = '0;
    logic [11:0] word;

    always_comb begin
        word = 12'hFFF;
        if (mode == 1)      word = addr ? val1 : val0;
        else if (mode == 2) word = 12'(100 + frames);
    end

    initial adc_bus.miso = 1'b1;
    always @(negedge adc_bus.cs) begin
        nfall = 0;
        adc_bus.miso = (mode == 0);
    end
    always @(posedge adc_bus.cs) frames++;
    always @(posedge adc_bus.dclk) begin
        mosi_bits = {mosi_bits[14:0], adc_bus.mosi};
        if (nfall == 2) addr = adc_bus.mosi;
    end
    always @(negedge adc_bus.dclk) begin
        nfall++;
        if (nfall >= 4 && nfall < 16) adc_bus.miso = word[15 - nfall];
    end

    // Pulse and cs-phase monitor
    int valid_cnt = 0, eos_cnt = 0;
    int cur_low = 0, last_low = 0, cur_high = 0, last_high = 0;
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) valid_cnt++;
        if (eos_o === 1'b1) eos_cnt++;
        if (cs_o === 1'b0) begin
            if (cur_high != 0) last_high = cur_high;
            cur_high = 0;
            cur_low++;
        end else begin
            if (cur_low != 0) last_low = cur_low;
            cur_low = 0;
            cur_high++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (valid_o !== 1'b1 && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_seen"}, 64'(valid_o), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs"},    64'(cs_o),    64'd1);
        check({tag, "_dclk"},  64'(dclk_o),  64'd0);
        check({tag, "_mosi"},  64'(mosi_o),  64'd0);
        check({tag, "_busy"},  64'(busy_o),  64'd0);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_eos"},   64'(eos_o),   64'd0);
        check({tag, "_data"},  64'(data_o),  64'd0);
        check({tag, "_ch"},    64'(ch_o),    64'd0);
        check({tag, "_dout"},  64'(dout_o),  64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_reset_values("rst");
        rst_i = 1'b1;
        @(negedge clk_i);

`ifdef SPI_ADC_SCAN_AVG_EN
        // Four frames of 100..103 average to 101
        mode = 2;
        frames = 0;
        valid_cnt = 0;
        ch_mask_i = 2'b01;
        pulse_start();
        check("avg_busy", 64'(busy_o), 64'd1);
        wait_valid("avg_v");
        check("avg_data", 64'(data_o), 64'd101);
        check("avg_ch",   64'(ch_o),   64'd0);
        check("avg_eos",  64'(eos_o),  64'd1);
        repeat (50) @(negedge clk_i);
        check("avg_nvalid", 64'(valid_cnt), 64'd1);
        check("avg_frames", 64'(frames),    64'd4);
        check("avg_slot0",  64'(dout_o),    64'h000065);
`else
        // T1: miso tied high, both channels
        eos_cnt = 0;
        ch_mask_i = 2'b11;
        pulse_start();
        check("t1_busy", 64'(busy_o), 64'd1);
        wait_valid("t1_v0");
        check("t1_ch0",   64'(ch_o),   64'd0);
        check("t1_d0",    64'(data_o), 64'hFFF);
        check("t1_eos0",  64'(eos_o),  64'd0);
        wait_valid("t1_v1");
        check("t1_ch1",   64'(ch_o),   64'd1);
        check("t1_d1",    64'(data_o), 64'hFFF);
        check("t1_eos1",  64'(eos_o),  64'd1);
        check("t1_idle",  64'(busy_o), 64'd0);
        @(negedge clk_i);
        check("t1_dout",  64'(dout_o),   64'hFFFFFF);
        check("t1_cslow", 64'(last_low), 64'd660);
        repeat (20) @(negedge clk_i);
        check("t1_neos",  64'(eos_cnt), 64'd1);

        // T2: distinct per-channel values, MOSI command for ch1
        mode = 1;
        pulse_start();
        wait_valid("t2_v0");
        check("t2_d0",   64'(data_o), 64'hA5C);
        wait_valid("t2_v1");
        check("t2_ch1",  64'(ch_o),      64'd1);
        check("t2_d1",   64'(data_o),    64'h3F1);
        check("t2_mosi", 64'(mosi_bits), 64'hE000);
        @(negedge clk_i);
        check("t2_dout",  64'(dout_o),   64'h3F1A5C);
        check("t2_cslow", 64'(last_low), 64'd660);

        // T3: ch1 only, slot 0 keeps its value
        val1 = 12'h123;
        ch_mask_i = 2'b10;
        valid_cnt = 0;
        eos_cnt = 0;
        pulse_start();
        wait_valid("t3_v");
        check("t3_ch",   64'(ch_o),   64'd1);
        check("t3_d",    64'(data_o), 64'h123);
        check("t3_eos",  64'(eos_o),  64'd1);
        @(negedge clk_i);
        check("t3_dout", 64'(dout_o), 64'h123A5C);
        repeat (50) @(negedge clk_i);
        check("t3_nvalid", 64'(valid_cnt), 64'd1);
        check("t3_neos",   64'(eos_cnt),   64'd1);

        // T4: continuous scanning, then drop cont mid-scan
        val1 = 12'h3F1;
        ch_mask_i = 2'b11;
        cont_i = 1'b1;
        pulse_start();
        wait_valid("t4_s1v0");
        wait_valid("t4_s1v1");
        check("t4_eos1", 64'(eos_o),     64'd1);
        check("t4_gap1", 64'(last_high), 64'd4);
        wait_valid("t4_s2v0");
        check("t4_s2ch", 64'(ch_o),      64'd0);
        check("t4_gap2", 64'(last_high), 64'd4);
        check("t4_busy", 64'(busy_o),    64'd1);
        cont_i = 1'b0;
        wait_valid("t4_s2v1");
        check("t4_s2ch1", 64'(ch_o),  64'd1);
        check("t4_eos2",  64'(eos_o), 64'd1);
        repeat (100) @(negedge clk_i);
        check("t4_idle", 64'(busy_o), 64'd0);
        check("t4_cs",   64'(cs_o),   64'd1);

        // T5: start while busy, then start with an empty mask
        valid_cnt = 0;
        eos_cnt = 0;
        pulse_start();
        repeat (100) @(negedge clk_i);
        ch_mask_i = 2'b01;
        pulse_start();
        check("t5_busy", 64'(busy_o), 64'd1);
        wait_valid("t5_v0");
        check("t5_d0", 64'(data_o), 64'hA5C);
        wait_valid("t5_v1");
        check("t5_eos", 64'(eos_o), 64'd1);
        repeat (50) @(negedge clk_i);
        check("t5_nvalid", 64'(valid_cnt), 64'd2);
        ch_mask_i = 2'b00;
        pulse_start();
        check("t5_m0busy", 64'(busy_o), 64'd0);
        repeat (30) @(negedge clk_i);
        check("t5_m0cs",  64'(cs_o),    64'd1);
        check("t5_m0eos", 64'(eos_cnt), 64'd1);

        // T6: reset mid-frame takes effect without waiting for a clock edge
        ch_mask_i = 2'b11;
        pulse_start();
        repeat (300) @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1 check_reset_values("t6");
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
